// File: rtl/cla_seq_adder.sv
// Nibble-serial WIDTH-bit add/subtract sequencer driving one external 4-bit CLA.
// One nibble per cycle, LSB first, with the carry chained through a register.
module cla_seq_adder #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             op_sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             overflow,
    output logic             zero,
    output logic [3:0]       cla_in1,
    output logic [3:0]       cla_in2,
    output logic             cla_cin,
    input  logic [3:0]       cla_sum,
    input  logic             cla_cout
);

    localparam int unsigned N  = WIDTH / 4;
    localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;
    localparam logic [IW-1:0] LastIdx = IW'(N - 1);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] op_a_q, op_a_d;
    logic [WIDTH-1:0] op_b_q, op_b_d;
    logic [WIDTH-1:0] ws_q, ws_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic             cr_q, cr_d;
    logic             carry_q, carry_d;
    logic             ovf_q, ovf_d;
    logic             zero_q, zero_d;

    logic [IW+1:0]    bit_base;
    logic [WIDTH-1:0] final_res;

    assign bit_base = {idx_q, 2'b00};

    // Working sum with the top nibble taken straight from the CLA on the last RUN cycle.
    always_comb begin
        final_res              = ws_q;
        final_res[WIDTH-1 -: 4] = cla_sum;
    end

    always_comb begin
        state_d  = state_q;
        op_a_d   = op_a_q;
        op_b_d   = op_b_q;
        ws_d     = ws_q;
        result_d = result_q;
        idx_d    = idx_q;
        cr_d     = cr_q;
        carry_d  = carry_q;
        ovf_d    = ovf_q;
        zero_d   = zero_q;
        cla_in1  = 4'h0;
        cla_in2  = 4'h0;
        cla_cin  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    op_a_d  = a;
                    op_b_d  = op_sub ? ~b : b;
                    cr_d    = op_sub;
                    idx_d   = '0;
                    ws_d    = '0;
                    state_d = StRun;
                end
            end
            StRun: begin
                cla_in1             = op_a_q[bit_base +: 4];
                cla_in2             = op_b_q[bit_base +: 4];
                cla_cin             = cr_q;
                ws_d[bit_base +: 4] = cla_sum;
                cr_d                = cla_cout;
                if (idx_q == LastIdx) begin
                    state_d  = StDone;
                    result_d = final_res;
                    carry_d  = cla_cout;
                    zero_d   = (final_res == '0);
                    ovf_d    = (op_a_q[WIDTH-1] == op_b_q[WIDTH-1]) &&
                               (cla_sum[3] != op_a_q[WIDTH-1]);
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            op_a_q   <= '0;
            op_b_q   <= '0;
            ws_q     <= '0;
            result_q <= '0;
            idx_q    <= '0;
            cr_q     <= 1'b0;
            carry_q  <= 1'b0;
            ovf_q    <= 1'b0;
            zero_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_a_q   <= op_a_d;
            op_b_q   <= op_b_d;
            ws_q     <= ws_d;
            result_q <= result_d;
            idx_q    <= idx_d;
            cr_q     <= cr_d;
            carry_q  <= carry_d;
            ovf_q    <= ovf_d;
            zero_q   <= zero_d;
        end
    end

    assign busy      = (state_q != StIdle);
    assign done      = (state_q == StDone);
    assign result    = result_q;
    assign carry_out = carry_q;
    assign overflow  = ovf_q;
    assign zero      = zero_q;

endmodule

// File: tb/tb_cla_seq_adder.sv
// Scoreboard bench for cla_seq_adder: a 4-bit CLA model closes the loop, a driver
// pushes reference results on acceptance and independent monitors check outputs.
module tb_cla_seq_adder;

    localparam int W = 32;
    localparam int N = W / 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          op_sub;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          busy;
    logic          done;
    logic [W-1:0]  result;
    logic          carry_out;
    logic          overflow;
    logic          zero;
    logic [3:0]    cla_in1;
    logic [3:0]    cla_in2;
    logic          cla_cin;
    logic [3:0]    cla_sum;
    logic          cla_cout;

    cla_seq_adder #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .op_sub    (op_sub),
        .a         (a),
        .b         (b),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .carry_out (carry_out),
        .overflow  (overflow),
        .zero      (zero),
        .cla_in1   (cla_in1),
        .cla_in2   (cla_in2),
        .cla_cin   (cla_cin),
        .cla_sum   (cla_sum),
        .cla_cout  (cla_cout)
    );

    // External 4-bit adder the sequencer time-shares.
    assign {cla_cout, cla_sum} = {1'b0, cla_in1} + {1'b0, cla_in2} + {4'b0, cla_cin};

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] res;
        logic         c;
        logic         v;
        logic         z;
        int           acc;
    } exp_t;

    exp_t         sb[$];
    int           n_checks = 0;
    int           n_pass   = 0;
    int           cyc      = 0;
    bit           mon_en   = 1'b0;
    bit           act_valid = 1'b0;
    logic [W-1:0] act_a, act_bp;
    logic         act_sub;
    int           act_c0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Reference: plain integer arithmetic on the operands.
    function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                   input logic s, input int acc);
        exp_t        e;
        longint      sx, sy, sr;
        logic [63:0] ux, uy;
        sx    = longint'($signed(x));
        sy    = longint'($signed(y));
        ux    = {32'b0, x};
        uy    = {32'b0, y};
        sr    = s ? sx - sy : sx + sy;
        e.res = s ? x - y : x + y;
        e.c   = s ? (x >= y) : ((ux + uy) > 64'hFFFF_FFFF);
        e.v   = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
        e.z   = (e.res == '0);
        e.acc = acc;
        return e;
    endfunction

    task automatic accept(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
        sb.push_back(model(x, y, s, cyc));
        act_a     = x;
        act_bp    = s ? ~y : y;
        act_sub   = s;
        act_c0    = cyc;
        act_valid = 1'b1;
    endtask

    task automatic wait_idle();
        int g = 0;
        @(negedge clk);
        while (busy && g < 40) begin
            @(negedge clk);
            g++;
        end
        if (g >= 40) check("idle_timeout", 64'(busy), 64'd0);
    endtask

    // Issue one op; leaves control #1 after the accepting edge with start low.
    task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y, input logic s,
                         input bit scramble);
        wait_idle();
        a      = x;
        b      = y;
        op_sub = s;
        start  = 1'b1;
        @(posedge clk);
        #1;
        accept(x, y, s);
        start = 1'b0;
        if (scramble) begin
            a      = $urandom;
            b      = $urandom;
            op_sub = 1'($urandom);
        end
    endtask

    task automatic drain();
        int g = 0;
        while (sb.size() != 0 && g < 40) begin
            @(negedge clk);
            g++;
        end
        check("drain", 64'(sb.size()), 64'd0);
    endtask

    // Result scoreboard monitor.
    always @(negedge clk) begin
        if (mon_en && done) begin
            if (sb.size() == 0) begin
                check("unexpected_done", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("result", 64'(result), 64'(e.res));
                check("carry_out", 64'(carry_out), 64'(e.c));
                check("overflow", 64'(overflow), 64'(e.v));
                check("zero", 64'(zero), 64'(e.z));
                check("latency", 64'(cyc - e.acc), 64'(N));
                check("busy_in_done", 64'(busy), 64'd1);
            end
        end
    end

    // CLA port monitor: nibble k of the latched operands and the carry into bit 4k.
    always @(negedge clk) begin
        if (mon_en) begin
            logic [8:0] got, want;
            got  = {cla_in1, cla_in2, cla_cin};
            want = '0;
            if (act_valid && cyc >= act_c0 && cyc - act_c0 < N) begin
                int          k;
                logic [63:0] m, s;
                k    = cyc - act_c0;
                m    = (64'd1 << (4 * k)) - 64'd1;
                s    = ({32'b0, act_a} & m) + ({32'b0, act_bp} & m) + 64'(act_sub);
                want = {4'(act_a >> (4 * k)), 4'(act_bp >> (4 * k)), 1'(s >> (4 * k))};
            end
            check("cla_ports", 64'(got), 64'(want));
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [W-1:0] specials[6];
        logic [W-1:0] x, y;
        specials = '{32'h0, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'h1, 32'hF0F0_0F0F};

        rst    = 1'b1;
        start  = 1'b0;
        op_sub = 1'b0;
        a      = '0;
        b      = '0;
        repeat (3) @(posedge clk);
        #1;
        rst    = 1'b0;
        mon_en = 1'b1;
        @(negedge clk);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_result", 64'(result), 64'd0);
        check("rst_flags", 64'({carry_out, overflow, zero}), 64'd0);

        // Directed cases.
        issue(32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 1'b0);
        issue(32'd5, 32'd7, 1'b1, 1'b0);
        issue(32'd7, 32'd5, 1'b1, 1'b1);
        issue(32'h7FFF_FFFF, 32'd1, 1'b0, 1'b0);
        issue(32'h8000_0000, 32'd1, 1'b1, 1'b1);
        drain();

        // start held high: one acceptance every N+2 cycles, operands changed mid-RUN.
        wait_idle();
        a      = 32'h1234_ABCD;
        b      = 32'h0F0F_F0F0;
        op_sub = 1'b0;
        start  = 1'b1;
        @(posedge clk);
        #1;
        accept(a, b, op_sub);
        for (int i = 0; i < 3; i++) begin
            a      = $urandom;
            b      = $urandom;
            op_sub = 1'(i);
            repeat (N + 2) @(posedge clk);
            #1;
            accept(a, b, op_sub);
        end
        start = 1'b0;
        drain();

        // start during DONE is ignored.
        issue(32'hDEAD_BEEF, 32'h0000_1111, 1'b1, 1'b0);
        repeat (N) @(posedge clk);
        @(negedge clk);
        a     = 32'h5555_5555;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (N + 4) @(negedge clk);
        check("done_start_ignored", 64'(busy), 64'd0);
        drain();

        // Reset mid-operation, sampled at E4.
        issue(32'hCAFE_0123, 32'h0BAD_F00D, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst       = 1'b0;
        act_valid = 1'b0;
        void'(sb.pop_back());
        @(negedge clk);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        check("abort_result", 64'(result), 64'd0);
        check("abort_flags", 64'({carry_out, overflow, zero}), 64'd0);
        issue(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0);
        drain();

        // Randomized add/sub pairs with occasional corner operands.
        for (int i = 0; i < 1000; i++) begin
            x = ($urandom_range(0, 7) == 0) ? specials[$urandom_range(0, 5)] : W'($urandom);
            y = ($urandom_range(0, 7) == 0) ? specials[$urandom_range(0, 5)] : W'($urandom);
            issue(x, y, 1'(i), 1'b1);
        end
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
